// File: rtl/noc_input_port.sv
// rtl/noc_input_port.sv - router input port: FWFT flit FIFO with XY route decode of the head flit
// rst_n is synchronous and active-high; the name is kept for port-list compatibility.
module noc_input_port #(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 3,
   parameter int DATASIZE = 40,
   parameter int LOCAL_X  = 0,
   parameter int LOCAL_Y  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATASIZE-1:0] data_in,
   input  logic                data_valid,
   output logic                full,
   output logic [3:0]          label,
   output logic [DATASIZE-1:0] data_out,
   input  logic                ready,
   output logic [WIDTH:0]      count,
   output logic                overflow
);

   localparam logic [WIDTH:0] DEPTH_C = DEPTH[WIDTH:0];
   localparam logic [1:0]     LX      = LOCAL_X[1:0];
   localparam logic [1:0]     LY      = LOCAL_Y[1:0];

   localparam logic [3:0] LBL_NONE = 4'd0;
   localparam logic [3:0] LBL_L    = 4'd1;
   localparam logic [3:0] LBL_N    = 4'd2;
   localparam logic [3:0] LBL_E    = 4'd3;
   localparam logic [3:0] LBL_S    = 4'd4;
   localparam logic [3:0] LBL_W    = 4'd5;

   logic [DATASIZE-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH:0]      count_q, count_d;
   logic                overflow_q, overflow_d;

   logic                empty;
   logic                push;
   logic                pop;
   logic [1:0]          dx;
   logic [1:0]          dy;

   assign empty    = (count_q == '0);
   assign full     = (count_q == DEPTH_C);
   assign pop      = ready && !empty;
   // A full FIFO still accepts a flit in the cycle it pops its head.
   assign push     = data_valid && (!full || pop);

   assign data_out = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign overflow = overflow_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (data_valid && full && !pop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not cleared; flits are simply forgotten by resetting the pointers.
   always_ff @(posedge clk) begin
      if (push && !rst_n) mem_q[wr_ptr_q] <= data_in;
   end

   assign dx = data_out[35:34];
   assign dy = data_out[33:32];

   always_comb begin
      label = LBL_NONE;
      if (!empty) begin
         if (dx > LX)      label = LBL_E;
         else if (dx < LX) label = LBL_W;
         else if (dy > LY) label = LBL_S;
         else if (dy < LY) label = LBL_N;
         else              label = LBL_L;
      end
   end

endmodule

// File: tb/tb_noc_input_port.sv
// tb/tb_noc_input_port.sv - directed self-checking bench for noc_input_port
// Two instances share stimulus: one at local (0,0), one at local (1,1).
module tb_noc_input_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [39:0] data_in;
   logic        data_valid;
   logic        ready;

   logic        full_a, full_b;
   logic [3:0]  label_a, label_b;
   logic [39:0] data_out_a, data_out_b;
   logic [3:0]  count_a, count_b;
   logic        overflow_a, overflow_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   noc_input_port #(.DEPTH(8), .WIDTH(3), .DATASIZE(40), .LOCAL_X(0), .LOCAL_Y(0)) u_dut_00 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .full(full_a), .label(label_a), .data_out(data_out_a), .ready(ready),
      .count(count_a), .overflow(overflow_a)
   );

   noc_input_port #(.DEPTH(8), .WIDTH(3), .DATASIZE(40), .LOCAL_X(1), .LOCAL_Y(1)) u_dut_11 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .full(full_b), .label(label_b), .data_out(data_out_b), .ready(ready),
      .count(count_b), .overflow(overflow_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [39:0] mk(input logic [3:0] dst, input logic [21:0] d);
      return {4'h3, dst, 8'h5A, d, 2'b01};
   endfunction

   task automatic push_one(input logic [39:0] f);
      data_valid = 1'b1;
      data_in    = f;
      step();
      data_valid = 1'b0;
   endtask

   task automatic pop_one();
      ready = 1'b1;
      step();
      ready = 1'b0;
   endtask

   logic [3:0]  route_dst [5] = '{4'b1001, 4'b0001, 4'b0110, 4'b0100, 4'b0101};
   logic [3:0]  route_lbl [5] = '{4'd3, 4'd5, 4'd4, 4'd2, 4'd1};
   logic [39:0] q [$];
   logic [39:0] f_new;

   initial begin
      rst_n      = 1'b1;
      data_in    = '0;
      data_valid = 1'b0;
      ready      = 1'b0;
      step();
      step();
      check("rst_full",     full_a,     0);
      check("rst_label",    label_a,    0);
      check("rst_count",    count_a,    0);
      check("rst_overflow", overflow_a, 0);
      rst_n = 1'b0;

      // single flit, local destination at (0,0)
      push_one(mk(4'b0000, 22'h1));
      check("single_label", label_a,    1);
      check("single_data",  data_out_a, mk(4'b0000, 22'h1));
      check("single_count", count_a,    1);
      pop_one();
      check("single_empty_count", count_a, 0);
      check("single_empty_label", label_a, 0);

      // XY route decode at local (1,1)
      for (int i = 0; i < 5; i++) begin
         push_one(mk(route_dst[i], 22'(16 + i)));
         check($sformatf("route_%0d", i), label_b, route_lbl[i]);
         pop_one();
      end

      // fill, drop, drain
      for (int i = 0; i < 8; i++) push_one(mk(4'h0, 22'(32 + i)));
      check("fill_count", count_a, 8);
      check("fill_full",  full_a,  1);
      check("fill_no_ovf", overflow_a, 0);
      push_one(mk(4'h0, 22'h3FF));
      check("drop_overflow", overflow_a, 1);
      check("drop_count",    count_a,    8);
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_%0d", i), data_out_a, mk(4'h0, 22'(32 + i)));
         step();
      end
      ready = 1'b0;
      check("drain_count",   count_a,    0);
      check("ovf_sticky",    overflow_a, 1);
      rst_n = 1'b1;
      step();
      rst_n = 1'b0;
      check("ovf_cleared",   overflow_a, 0);

      // full with simultaneous push and pop
      for (int i = 0; i < 8; i++) push_one(mk(4'h0, 22'(64 + i)));
      f_new      = mk(4'h0, 22'h77);
      data_valid = 1'b1;
      data_in    = f_new;
      ready      = 1'b1;
      step();
      data_valid = 1'b0;
      check("pp_count",    count_a,    8);
      check("pp_overflow", overflow_a, 0);
      check("pp_full",     full_a,     1);
      for (int i = 1; i < 8; i++) begin
         check($sformatf("pp_drain_%0d", i), data_out_a, mk(4'h0, 22'(64 + i)));
         step();
      end
      check("pp_new_last", data_out_a, f_new);
      step();
      ready = 1'b0;
      check("pp_empty", count_a, 0);

      // wrap-around stream with alternating ready
      begin
         int  sent = 0;
         int  cyc  = 0;
         logic do_pop;
         while ((sent < 20 || q.size() > 0) && cyc < 200) begin
            ready      = (cyc % 2 == 0);
            do_pop     = ready && (q.size() > 0);
            data_valid = (sent < 20) && ((q.size() < 8) || do_pop);
            data_in    = mk(4'h0, 22'(200 + sent));
            if (do_pop) check("wrap_head", data_out_a, q[0]);
            step();
            if (do_pop) void'(q.pop_front());
            if (data_valid) begin
               q.push_back(data_in);
               sent++;
            end
            check("wrap_count", count_a, 64'(q.size()));
            cyc++;
         end
         data_valid = 1'b0;
         ready      = 1'b0;
         check("wrap_timeout",  64'(cyc < 200), 1);
         check("wrap_overflow", overflow_a, 0);
      end

      // reset mid-stream
      for (int i = 0; i < 5; i++) push_one(mk(4'h0, 22'(300 + i)));
      check("mid_count", count_a, 5);
      rst_n = 1'b1;
      step();
      rst_n = 1'b0;
      check("mid_rst_count", count_a,    0);
      check("mid_rst_label", label_a,    0);
      check("mid_rst_ovf",   overflow_a, 0);
      push_one(mk(4'b0000, 22'h155));
      check("post_rst_data",  data_out_a, mk(4'b0000, 22'h155));
      check("post_rst_label", label_a,    1);
      check("post_rst_count", count_a,    1);
      pop_one();
      check("post_rst_empty", count_a, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
